// File: rtl/display_pkg.sv
// Shared types and constants for the display compositor.
package display_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [31:0] IR_START_CODE_A = 32'h20DF_5BA4;
  localparam logic [31:0] IR_START_CODE_B = 32'h20DF_5AA5;

  typedef enum logic [1:0] {
    START = 2'd0,
    GAME  = 2'd1,
    OVER  = 2'd2
  } screen_state_t;

  // Halve the brightness of each 8-bit channel independently.
  function automatic logic [PIXEL_W-1:0] dim_pixel(input logic [PIXEL_W-1:0] p);
    return {p[23:16] >> 1, p[15:8] >> 1, p[7:0] >> 1};
  endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// Fixed-priority layer select: the lowest-index layer with a hit wins.
module layer_priority_sel
  import display_pkg::*;
#(
  parameter int NUM_LAYERS = 8
) (
  input  logic [NUM_LAYERS-1:0]         i_hit,
  input  logic [PIXEL_W*NUM_LAYERS-1:0] i_pixels,
  output logic [PIXEL_W-1:0]            o_pixel,
  output logic                          o_any_hit
);

  // Walk from lowest to highest priority so the last assignment is the winner.
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    o_pixel   = '0;
    o_any_hit = |i_hit;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (i_hit[i]) o_pixel = i_pixels[i*PIXEL_W +: PIXEL_W];
    end
  end

endmodule

// File: rtl/display_compositor.sv
// Layer compositor with border overlay and frame-synchronous screen-mode FSM.
// Two-stage pixel pipeline: stage 1 registers inputs and layer hits, stage 2
// resolves priority, applies the screen mode and registers the outputs.
module display_compositor
  import display_pkg::*;
#(
  parameter int          NUM_LAYERS   = 8,
  parameter logic [23:0] KEY_COLOR    = 24'h00_00_00,
  parameter int          BORDER_X     = 960,
  parameter int          BORDER_Y     = 640,
  parameter logic [23:0] BORDER_COLOR = 24'hFF_FF_FF,
  parameter int          OVER_FRAMES  = 180,
  parameter logic [31:0] START_CODE_A = IR_START_CODE_A,
  parameter logic [31:0] START_CODE_B = IR_START_CODE_B
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          nf_in,
  input  logic [PIXEL_W*NUM_LAYERS-1:0] layer_pixels_in,
  input  logic [NUM_LAYERS-1:0]         layer_enable_in,
  input  logic                          camera_sw,
  input  logic [PIXEL_W-1:0]            camera_pixel_in,
  input  logic [PIXEL_W-1:0]            start_pixel_in,
  input  logic                          ir_valid_in,
  input  logic [31:0]                   ir_in,
  input  logic [2:0]                    player_health_in,
  input  logic [2:0]                    opponent_health_in,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic [10:0]                   hcount_out,
  output logic [9:0]                    vcount_out,
  output logic [1:0]                    screen_state_out
);

  localparam int              CNT_W    = $clog2(OVER_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [10:0]      BX       = 11'(BORDER_X);
  localparam logic [9:0]       BY       = 10'(BORDER_Y);

  // Stage 1 registers
  logic [PIXEL_W*NUM_LAYERS-1:0] r_pixels;
  logic [NUM_LAYERS-1:0]         r_hit;
  logic                          r_camera_sw;
  logic [PIXEL_W-1:0]            r_camera_pixel;
  logic [PIXEL_W-1:0]            r_start_pixel;
  logic [10:0]                   r_hcount;
  logic [9:0]                    r_vcount;

  // Control state
  screen_state_t    r_state;
  logic             r_req;
  logic [CNT_W-1:0] r_frame_cnt;

  logic [NUM_LAYERS-1:0] w_hit;
  logic [PIXEL_W-1:0]    w_win_pixel;
  logic                  w_any_hit;
  logic                  w_border;
  logic [PIXEL_W-1:0]    w_game_pixel;
  logic [PIXEL_W-1:0]    w_mode_pixel;
  logic                  w_start_hit;
  logic                  w_req_pending;
  logic                  w_health_zero;

  // A layer hits when it is enabled and not the transparency key.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_hit[i] = layer_enable_in[i] &&
                 (layer_pixels_in[i*PIXEL_W +: PIXEL_W] != KEY_COLOR);
    end
  end

  // Stage 1: capture the pixel inputs and the hit vector.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pixels       <= '0;
      r_hit          <= '0;
      r_camera_sw    <= 1'b0;
      r_camera_pixel <= '0;
      r_start_pixel  <= '0;
      r_hcount       <= '0;
      r_vcount       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_pixels       <= layer_pixels_in;
      r_hit          <= w_hit;
      r_camera_sw    <= camera_sw;
      r_camera_pixel <= camera_pixel_in;
      r_start_pixel  <= start_pixel_in;
      r_hcount       <= hcount_in;
      r_vcount       <= vcount_in;
    end
  end

  layer_priority_sel #(
    .NUM_LAYERS(NUM_LAYERS)
  ) u_layer_priority_sel (
    .i_hit     (r_hit),
    .i_pixels  (r_pixels),
    .o_pixel   (w_win_pixel),
    .o_any_hit (w_any_hit)
  );

  // Stage 2 combinational: border overlay, background, then screen mode.
  always_comb begin
    w_border = ((r_hcount == BX) && (r_vcount <= BY)) ||
               ((r_vcount == BY) && (r_hcount <= BX));
    if (w_border)         w_game_pixel = BORDER_COLOR;
    else if (w_any_hit)   w_game_pixel = w_win_pixel;
    else if (r_camera_sw) w_game_pixel = r_camera_pixel;
    else                  w_game_pixel = '0;

    case (r_state)
      START:   w_mode_pixel = r_start_pixel;
      GAME:    w_mode_pixel = w_game_pixel;
      OVER:    w_mode_pixel = dim_pixel(w_game_pixel);
      default: w_mode_pixel = '0;
    endcase
  end

  // Stage 2: register the composited pixel and the delayed counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out  <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      pixel_out  <= w_mode_pixel;
      hcount_out <= r_hcount;
      vcount_out <= r_vcount;
    end
  end

  assign w_start_hit   = ir_valid_in && ((ir_in == START_CODE_A) || (ir_in == START_CODE_B));
  assign w_req_pending = r_req || w_start_hit;
  assign w_health_zero = (player_health_in == 3'd0) || (opponent_health_in == 3'd0);

  // Screen-mode FSM, start-request latch and OVER frame counter; mode changes only on nf_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= START;
      r_req       <= 1'b0;
      r_frame_cnt <= '0;
    end else if (nf_in) begin
      r_req <= 1'b0;
      case (r_state)
        START: if (w_req_pending) r_state <= GAME;
        GAME: begin
          if (w_health_zero) begin
            r_state     <= OVER;
            r_frame_cnt <= '0;
          end
        end
        OVER: begin
          if (w_req_pending || (r_frame_cnt == CNT_LAST)) r_state <= START;
          else if (r_frame_cnt != CNT_MAX)               r_frame_cnt <= r_frame_cnt + 1'b1;
        end
        default: r_state <= START;
      endcase
    end else if (w_start_hit) begin
      r_req <= 1'b1;
    end
  end

  assign screen_state_out = r_state;

endmodule

// File: tb/tb_display_compositor.sv
// Directed self-checking bench for display_compositor.
module tb_display_compositor;

  localparam int NL = 8;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [10:0]     hcount_in;
  logic [9:0]      vcount_in;
  logic            nf_in;
  logic [24*NL-1:0] layer_pixels_in;
  logic [NL-1:0]   layer_enable_in;
  logic            camera_sw;
  logic [23:0]     camera_pixel_in;
  logic [23:0]     start_pixel_in;
  logic            ir_valid_in;
  logic [31:0]     ir_in;
  logic [2:0]      player_health_in;
  logic [2:0]      opponent_health_in;
  logic [23:0]     pixel_out;
  logic [10:0]     hcount_out;
  logic [9:0]      vcount_out;
  logic [1:0]      screen_state_out;

  int checks = 0;
  int errors = 0;

  display_compositor #(.NUM_LAYERS(NL)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .nf_in              (nf_in),
    .layer_pixels_in    (layer_pixels_in),
    .layer_enable_in    (layer_enable_in),
    .camera_sw          (camera_sw),
    .camera_pixel_in    (camera_pixel_in),
    .start_pixel_in     (start_pixel_in),
    .ir_valid_in        (ir_valid_in),
    .ir_in              (ir_in),
    .player_health_in   (player_health_in),
    .opponent_health_in (opponent_health_in),
    .pixel_out          (pixel_out),
    .hcount_out         (hcount_out),
    .vcount_out         (vcount_out),
    .screen_state_out   (screen_state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse_nf();
    nf_in = 1'b1;
    tick();
    nf_in = 1'b0;
  endtask

  task automatic send_ir(input logic [31:0] code);
    ir_valid_in = 1'b1;
    ir_in       = code;
    tick();
    ir_valid_in = 1'b0;
    ir_in       = '0;
  endtask

  initial begin
    rst_in             = 1'b1;
    hcount_in          = 11'd5;
    vcount_in          = 10'd7;
    nf_in              = 1'b0;
    layer_pixels_in    = '0;
    layer_enable_in    = '0;
    camera_sw          = 1'b0;
    camera_pixel_in    = '0;
    start_pixel_in     = 24'h123456;
    ir_valid_in        = 1'b0;
    ir_in              = '0;
    player_health_in   = 3'd7;
    opponent_health_in = 3'd7;

    // Reset state
    tick(3);
    check("rst_pixel", 32'(pixel_out), 32'h0);
    check("rst_state", 32'(screen_state_out), 32'd0);
    check("rst_hcount", 32'(hcount_out), 32'd0);

    // Release: first output is still the flushed zero, then the start image
    rst_in = 1'b0;
    tick();
    check("fill_pixel0", 32'(pixel_out), 32'h0);
    tick();
    check("start_pixel", 32'(pixel_out), 32'h123456);
    check("start_hcount", 32'(hcount_out), 32'd5);
    check("start_vcount", 32'(vcount_out), 32'd7);
    check("start_state", 32'(screen_state_out), 32'd0);

    // Non-start IR code is ignored
    send_ir(32'h20DF_0000);
    pulse_nf();
    check("ir_other_state", 32'(screen_state_out), 32'd0);

    // Start code mid-frame takes effect only at the next nf_in
    send_ir(32'h20DF_5AA5);
    tick(3);
    check("ir_wait_state", 32'(screen_state_out), 32'd0);
    pulse_nf();
    check("ir_game_state", 32'(screen_state_out), 32'd1);

    // Priority: layers 2 and 5 opaque, layer 2 wins
    hcount_in = 11'd100;
    vcount_in = 10'd100;
    layer_enable_in = 8'b0010_0100;
    layer_pixels_in[2*24 +: 24] = 24'hAA0000;
    layer_pixels_in[5*24 +: 24] = 24'h00BB00;
    tick(2);
    check("prio_l2", 32'(pixel_out), 32'hAA0000);
    layer_pixels_in[2*24 +: 24] = 24'h000000;
    tick(2);
    check("prio_l5_key", 32'(pixel_out), 32'h00BB00);

    // Background selection with no hits
    layer_enable_in = '0;
    camera_sw       = 1'b1;
    camera_pixel_in = 24'h0F0F0F;
    tick(2);
    check("bg_camera", 32'(pixel_out), 32'h0F0F0F);
    camera_sw = 1'b0;
    tick(2);
    check("bg_black", 32'(pixel_out), 32'h0);

    // Border overrides layers; just past the border corner it does not
    layer_enable_in = 8'b0010_0000;
    hcount_in = 11'd960;
    vcount_in = 10'd100;
    tick(2);
    check("border_vert", 32'(pixel_out), 32'hFFFFFF);
    vcount_in = 10'd641;
    tick(2);
    check("border_past_y", 32'(pixel_out), 32'h00BB00);
    hcount_in = 11'd0;
    vcount_in = 10'd640;
    tick(2);
    check("border_horiz", 32'(pixel_out), 32'hFFFFFF);
    hcount_in = 11'd961;
    tick(2);
    check("border_past_x", 32'(pixel_out), 32'h00BB00);

    // Healthy frame keeps GAME
    pulse_nf();
    check("game_hold", 32'(screen_state_out), 32'd1);

    // Game over: waits for nf_in, then dims the composite
    opponent_health_in = 3'd0;
    tick();
    check("over_wait", 32'(screen_state_out), 32'd1);
    pulse_nf();
    check("over_state", 32'(screen_state_out), 32'd2);
    hcount_in = 11'd10;
    vcount_in = 10'd10;
    layer_enable_in = 8'b0000_0001;
    layer_pixels_in[0*24 +: 24] = 24'hFF8040;
    tick(2);
    check("over_dim", 32'(pixel_out), 32'h7F4020);

    // Automatic return to START after 180 frames in OVER
    for (int f = 0; f < 179; f++) begin
      pulse_nf();
      tick();
    end
    check("over_179", 32'(screen_state_out), 32'd2);
    pulse_nf();
    check("over_180", 32'(screen_state_out), 32'd0);

    // Start strobe coincident with nf_in is honoured at that nf_in
    ir_valid_in = 1'b1;
    ir_in       = 32'h20DF_5BA4;
    nf_in       = 1'b1;
    tick();
    ir_valid_in = 1'b0;
    nf_in       = 1'b0;
    check("ir_same_nf", 32'(screen_state_out), 32'd1);

    // Zero health plus pending request: go to OVER and drop the request
    send_ir(32'h20DF_5AA5);
    pulse_nf();
    check("simul_over", 32'(screen_state_out), 32'd2);
    pulse_nf();
    check("req_dropped", 32'(screen_state_out), 32'd2);

    // Asynchronous reset mid-frame in OVER
    hcount_in = 11'd33;
    vcount_in = 10'd44;
    tick(2);
    check("pre_rst_pixel", 32'(pixel_out), 32'h7F4020);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_pixel", 32'(pixel_out), 32'h0);
    check("async_rst_state", 32'(screen_state_out), 32'd0);
    check("async_rst_hcount", 32'(hcount_out), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();
    check("refill_hcount0", 32'(hcount_out), 32'd0);
    tick();
    check("refill_hcount", 32'(hcount_out), 32'd33);
    check("refill_vcount", 32'(vcount_out), 32'd44);
    check("refill_pixel", 32'(pixel_out), 32'h123456);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
